turf_ram_sequencer: RTL and testbench

Game-level controller and single-port arbiter for the 3-bit turf RAM (address = {x[7:0], y[6:0]}). It sequences each round through four phases: clear the arena, paint player positions on every movement tick until the round timer expires, tally every cell, and publish counts and the winner. It is the only block that drives the RAM write/read port. It sits between the rate divider, the direction/move logic and the RAM, and replaces the free-running per-phase writer/reader pair.

---
 rtl/turf_pkg.sv | 51 +++++
 rtl/turf_tally.sv | 91 +++++++++
 rtl/turf_ram_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_turf_ram_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turf_pkg.sv
// turf_pkg: shared definitions for the turf RAM game controller.
// Holds the arena size defaults, the cell colour codes, the sequencer
// state encoding and helpers that pack/unpack a {x[7:0], y[6:0]} address.
package turf_pkg;

    localparam int X_MAX_DEFAULT      = 158;
    localparam int Y_MAX_DEFAULT      = 119;
    localparam int ROUND_SECS_DEFAULT = 60;

    localparam logic [2:0] COL_NONE = 3'b000;
    localparam logic [2:0] COL_P1   = 3'b001;
    localparam logic [2:0] COL_P2   = 3'b010;
    localparam logic [2:0] COL_P3   = 3'b100;
    localparam logic [2:0] COL_P4   = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PLAY,
        PAINT,
        TALLY,
        DRAIN,
        DECIDE,
        RESULT
    } turf_state_t;

    function automatic logic [14:0] pack_addr(input logic [7:0] x, input logic [6:0] y);
        return {x, y};
    endfunction

    function automatic logic [7:0] addr_x(input logic [14:0] a);
        return a[14:7];
    endfunction

    function automatic logic [6:0] addr_y(input logic [14:0] a);
        return a[6:0];
    endfunction

    // Paint slot 0..3 belongs to player 1..4.
    function automatic logic [2:0] slot_colour(input logic [1:0] s);
        logic [2:0] c;
        case (s)
            2'd0:    c = COL_P1;
            2'd1:    c = COL_P2;
            2'd2:    c = COL_P3;
            default: c = COL_P4;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/turf_tally.sv
// turf_tally: cell-count pipeline and winner decision.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   clear_counts  zeroes counts, winner and the sample flag (start of a round)
//   sample_req    an address is on the RAM port this cycle; its data arrives next cycle
//   decide        register the winner from the final counts
//   ram_q         RAM read data
//   count1..4     cells owned by each player
//   winner        index of the player with the highest count, lowest index on ties
module turf_tally
    import turf_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_counts,
    input  logic        sample_req,
    input  logic        decide,
    input  logic [2:0]  ram_q,
    output logic [14:0] count1,
    output logic [14:0] count2,
    output logic [14:0] count3,
    output logic [14:0] count4,
    output logic [1:0]  winner
);

    logic        sample_valid;
    logic [1:0]  best_idx;
    logic [14:0] best_cnt;

    // RAM data lags the address by one cycle, so the request is delayed one
    // cycle to mark when ram_q holds the cell being tallied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= sample_req & ~clear_counts;
        end
    end

    // Counters only move on valid samples; unknown colours are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count1 <= '0;
            count2 <= '0;
            count3 <= '0;
            count4 <= '0;
        end else if (clear_counts) begin
            count1 <= '0;
            count2 <= '0;
            count3 <= '0;
            count4 <= '0;
        end else if (sample_valid) begin
            case (ram_q)
                COL_P1:  count1 <= count1 + 15'd1;
                COL_P2:  count2 <= count2 + 15'd1;
                COL_P3:  count3 <= count3 + 15'd1;
                COL_P4:  count4 <= count4 + 15'd1;
                default: ;
            endcase
        end
    end

    // Strict greater-than keeps the earlier (lower-index) player on ties.
    always_comb begin
        best_idx = 2'd0;
        best_cnt = count1;
        if (count2 > best_cnt) begin
            best_idx = 2'd1;
            best_cnt = count2;
        end
        if (count3 > best_cnt) begin
            best_idx = 2'd2;
            best_cnt = count3;
        end
        if (count4 > best_cnt) begin
            best_idx = 2'd3;
        end
    end

    // Winner is captured once per round and held through RESULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner <= 2'd0;
        end else if (clear_counts) begin
            winner <= 2'd0;
        end else if (decide) begin
            winner <= best_idx;
        end
    end

endmodule

// File: rtl/turf_ram_sequencer.sv
// turf_ram_sequencer: round controller and sole owner of the turf RAM port.
// A round clears the arena, paints the four players on every move_tick until
// the timer runs out, reads back every cell to count ownership, then publishes
// the counts and the winner.
// Ports:
//   CLOCK_50, resetn             clock, asynchronous active-low reset
//   start                        begin a round from IDLE or RESULT
//   move_tick, sec_tick          paint request, 1 Hz timer pulse
//   p1..p4                       player positions {x, y}
//   ram_q                        RAM read data (one cycle after the address)
//   ram_wren/address/data        registered RAM port
//   running, busy, done          phase flags
//   time_left                    remaining seconds
//   p1_count..p4_count, winner   round results
module turf_ram_sequencer
    import turf_pkg::*;
#(
    parameter int ROUND_SECS = ROUND_SECS_DEFAULT,
    parameter int X_MAX      = X_MAX_DEFAULT,
    parameter int Y_MAX      = Y_MAX_DEFAULT
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic        move_tick,
    input  logic        sec_tick,
    input  logic [14:0] p1,
    input  logic [14:0] p2,
    input  logic [14:0] p3,
    input  logic [14:0] p4,
    input  logic [2:0]  ram_q,
    output logic        ram_wren,
    output logic [14:0] ram_address,
    output logic [2:0]  ram_data,
    output logic        running,
    output logic        busy,
    output logic        done,
    output logic [7:0]  time_left,
    output logic [14:0] p1_count,
    output logic [14:0] p2_count,
    output logic [14:0] p3_count,
    output logic [14:0] p4_count,
    output logic [1:0]  winner
);

    localparam logic [7:0] X_LAST    = 8'(X_MAX);
    localparam logic [6:0] Y_LAST    = 7'(Y_MAX);
    localparam logic [7:0] ROUND_LEN = 8'(ROUND_SECS);

    turf_state_t state, state_next;
    logic [7:0]  sweep_x, sweep_x_next, step_x;
    logic [6:0]  sweep_y, sweep_y_next, step_y;
    logic        sweep_last;
    logic [1:0]  slot, slot_next, emit_slot;
    logic [14:0] emit_pos;
    logic        emit_valid;
    logic        pending, pending_next;
    logic [7:0]  time_next;
    logic        wren_next;
    logic [14:0] address_next;
    logic [2:0]  data_next;
    logic        clear_counts;

    // The sweep walks x outer, y inner and never visits y beyond the last row.
    always_comb begin
        sweep_last = (sweep_x == X_LAST) && (sweep_y == Y_LAST);
        step_x     = sweep_x;
        step_y     = sweep_y + 7'd1;
        if (sweep_y == Y_LAST) begin
            step_x = sweep_x + 8'd1;
            step_y = 7'd0;
        end
    end

    // Slot that goes onto the bus at the next edge: slot 0 when a burst
    // starts, otherwise the one after the slot currently shown.
    always_comb begin
        emit_slot = (state == PAINT) ? slot + 2'd1 : 2'd0;
        case (emit_slot)
            2'd0:    emit_pos = p1;
            2'd1:    emit_pos = p2;
            2'd2:    emit_pos = p3;
            default: emit_pos = p4;
        endcase
        emit_valid = (addr_x(emit_pos) <= X_LAST) && (addr_y(emit_pos) <= Y_LAST);
    end

    // Next-state and next RAM-port values. The RAM port is loaded on the same
    // edge as the state change, so the bus always shows the access that
    // belongs to the current state (first write one cycle after the trigger).
    always_comb begin
        state_next   = state;
        sweep_x_next = sweep_x;
        sweep_y_next = sweep_y;
        slot_next    = slot;
        pending_next = pending;
        time_next    = time_left;
        wren_next    = 1'b0;
        address_next = ram_address;
        data_next    = COL_NONE;
        clear_counts = 1'b0;

        if ((state == PLAY || state == PAINT) && sec_tick && time_left != 8'd0) begin
            time_next = time_left - 8'd1;
        end

        case (state)
            IDLE, RESULT: begin
                if (start) begin
                    state_next   = CLEAR;
                    clear_counts = 1'b1;
                    time_next    = ROUND_LEN;
                    pending_next = 1'b0;
                    sweep_x_next = 8'd0;
                    sweep_y_next = 7'd0;
                    wren_next    = 1'b1;
                    address_next = pack_addr(8'd0, 7'd0);
                end
            end
            CLEAR: begin
                if (sweep_last) begin
                    state_next = PLAY;
                end else begin
                    sweep_x_next = step_x;
                    sweep_y_next = step_y;
                    wren_next    = 1'b1;
                    address_next = pack_addr(step_x, step_y);
                end
            end
            PLAY: begin
                // A move always paints before the timer is allowed to end the round.
                if (move_tick || pending) begin
                    state_next   = PAINT;
                    slot_next    = 2'd0;
                    pending_next = 1'b0;
                    wren_next    = emit_valid;
                    address_next = emit_pos;
                    data_next    = slot_colour(emit_slot);
                end else if (time_left == 8'd0) begin
                    state_next   = TALLY;
                    sweep_x_next = 8'd0;
                    sweep_y_next = 7'd0;
                    address_next = pack_addr(8'd0, 7'd0);
                end
            end
            PAINT: begin
                if (move_tick) begin
                    pending_next = 1'b1;
                end
                if (slot == 2'd3) begin
                    state_next = PLAY;
                end else begin
                    slot_next    = emit_slot;
                    wren_next    = emit_valid;
                    address_next = emit_pos;
                    data_next    = slot_colour(emit_slot);
                end
            end
            TALLY: begin
                if (sweep_last) begin
                    state_next = DRAIN;
                end else begin
                    sweep_x_next = step_x;
                    sweep_y_next = step_y;
                    address_next = pack_addr(step_x, step_y);
                end
            end
            DRAIN:   state_next = DECIDE;
            DECIDE:  state_next = RESULT;
            default: state_next = IDLE;
        endcase
    end

    // State and RAM-port registers; reset drops ram_wren immediately.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            sweep_x     <= 8'd0;
            sweep_y     <= 7'd0;
            slot        <= 2'd0;
            pending     <= 1'b0;
            time_left   <= 8'd0;
            ram_wren    <= 1'b0;
            ram_address <= 15'd0;
            ram_data    <= COL_NONE;
        end else begin
            state       <= state_next;
            sweep_x     <= sweep_x_next;
            sweep_y     <= sweep_y_next;
            slot        <= slot_next;
            pending     <= pending_next;
            time_left   <= time_next;
            ram_wren    <= wren_next;
            ram_address <= address_next;
            ram_data    <= data_next;
        end
    end

    assign running = (state == PLAY) || (state == PAINT);
    assign busy    = (state != IDLE) && (state != RESULT);
    assign done    = (state == RESULT);

    turf_tally u_tally (
        .clk          (CLOCK_50),
        .rst_n        (resetn),
        .clear_counts (clear_counts),
        .sample_req   (state == TALLY),
        .decide       (state == DECIDE),
        .ram_q        (ram_q),
        .count1       (p1_count),
        .count2       (p2_count),
        .count3       (p3_count),
        .count4       (p4_count),
        .winner       (winner)
    );

endmodule

// File: tb/tb_turf_ram_sequencer.sv
// tb_turf_ram_sequencer: self-checking bench for turf_ram_sequencer on a
// reduced 8x6 arena. A behavioural RAM sits on the DUT port; an arena array
// in the bench tracks what every cell should hold, and expected counts and
// winner are derived from that arena.
module tb_turf_ram_sequencer;

    localparam int XM     = 7;
    localparam int YM     = 5;
    localparam int RS     = 2;
    localparam int NCELLS = (XM + 1) * (YM + 1);

    logic        CLOCK_50;
    logic        resetn, start, move_tick, sec_tick;
    logic [14:0] p1, p2, p3, p4;
    logic [2:0]  ram_q;
    logic        ram_wren;
    logic [14:0] ram_address;
    logic [2:0]  ram_data;
    logic        running, busy, done;
    logic [7:0]  time_left;
    logic [14:0] p1_count, p2_count, p3_count, p4_count;
    logic [1:0]  winner;

    typedef struct {
        int          cyc;
        logic [14:0] addr;
        logic [2:0]  data;
    } wr_t;

    int          checks;
    int          failures;
    int          cyc;
    wr_t         wlog[$];
    wr_t         expq[$];
    logic [2:0]  mem   [0:32767];
    logic [2:0]  arena [0:32767];
    logic        bd_we;
    logic [14:0] bd_addr;
    logic [2:0]  bd_data;

    turf_ram_sequencer #(
        .ROUND_SECS (RS),
        .X_MAX      (XM),
        .Y_MAX      (YM)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .start       (start),
        .move_tick   (move_tick),
        .sec_tick    (sec_tick),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .p4          (p4),
        .ram_q       (ram_q),
        .ram_wren    (ram_wren),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .running     (running),
        .busy        (busy),
        .done        (done),
        .time_left   (time_left),
        .p1_count    (p1_count),
        .p2_count    (p2_count),
        .p3_count    (p3_count),
        .p4_count    (p4_count),
        .winner      (winner)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Single-port RAM with registered read; the backdoor only acts when the
    // DUT is not writing.
    always @(posedge CLOCK_50) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        else if (bd_we) mem[bd_addr] <= bd_data;
        ram_q <= mem[ram_address];
    end

    // Every visible write is logged with the cycle it appeared in.
    always @(negedge CLOCK_50) begin : monitor
        wr_t w;
        if (ram_wren) begin
            w.cyc  = cyc;
            w.addr = ram_address;
            w.data = ram_data;
            wlog.push_back(w);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of pulses; called and returns at a falling edge.
    task automatic applyStimulus(input logic s, input logic m, input logic t);
        start     = s;
        move_tick = m;
        sec_tick  = t;
        @(negedge CLOCK_50);
        start     = 1'b0;
        move_tick = 1'b0;
        sec_tick  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    function automatic logic [14:0] getPos(input int i);
        case (i)
            0:       return p1;
            1:       return p2;
            2:       return p3;
            default: return p4;
        endcase
    endfunction

    function automatic logic [2:0] colourOf(input int i);
        case (i)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b110;
        endcase
    endfunction

    function automatic bit posValid(input logic [14:0] p);
        return (int'(p[14:7]) <= XM) && (int'(p[6:0]) <= YM);
    endfunction

    function automatic logic [14:0] randPos();
        logic [7:0] x;
        logic [6:0] y;
        x = 8'($urandom_range(0, XM));
        y = 7'($urandom_range(0, YM));
        if ($urandom_range(0, 7) == 0) x = 8'($urandom_range(XM + 1, 255));
        else if ($urandom_range(0, 7) == 0) y = 7'($urandom_range(YM + 1, 127));
        return {x, y};
    endfunction

    task automatic randomizePlayers();
        p1 = randPos();
        p2 = randPos();
        p3 = randPos();
        p4 = randPos();
    endtask

    // Expected paint burst starting in cycle t0; also updates the arena.
    task automatic expectBurst(input int t0);
        wr_t w;
        for (int i = 0; i < 4; i++) begin
            if (posValid(getPos(i))) begin
                w.cyc  = t0 + i;
                w.addr = getPos(i);
                w.data = colourOf(i);
                expq.push_back(w);
                arena[getPos(i)] = colourOf(i);
            end
        end
    endtask

    task automatic compareWrites(input string tag, input int base);
        int  n, bad;
        wr_t g, x;
        n = wlog.size() - base;
        checkOutput({tag, "_count"}, n, expq.size());
        bad = 0;
        for (int k = 0; k < n && k < expq.size(); k++) begin
            g = wlog[base + k];
            x = expq[k];
            if (g.cyc != x.cyc || g.addr !== x.addr || g.data !== x.data) bad++;
        end
        checkOutput({tag, "_match"}, bad, 0);
        expq.delete();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_wren"}, ram_wren, 0);
        checkOutput({tag, "_addr"}, ram_address, 0);
        checkOutput({tag, "_data"}, ram_data, 0);
        checkOutput({tag, "_flags"}, {running, busy, done}, 0);
        checkOutput({tag, "_time"}, time_left, 0);
        checkOutput({tag, "_counts"}, {p1_count, p2_count, p3_count, p4_count}, 0);
        checkOutput({tag, "_winner"}, winner, 0);
    endtask

    // Start a round and verify the full clear sweep.
    task automatic doClear(input string tag);
        int         base, t0, bad, maxy, n;
        wr_t        e;
        logic [14:0] ea;
        base = wlog.size();
        applyStimulus(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        checkOutput({tag, "_first_counts"}, {p1_count, p2_count, p3_count, p4_count}, 0);
        checkOutput({tag, "_first_winner"}, winner, 0);
        checkOutput({tag, "_first_time"}, time_left, RS);
        for (int i = 0; i < NCELLS + 10 && !running; i++) @(negedge CLOCK_50);
        checkOutput({tag, "_length"}, cyc - t0, NCELLS);
        n = wlog.size() - base;
        checkOutput({tag, "_writes"}, n, NCELLS);
        bad  = 0;
        maxy = 0;
        for (int k = 0; k < n; k++) begin
            e  = wlog[base + k];
            ea = {8'(k / (YM + 1)), 7'(k % (YM + 1))};
            if (e.addr !== ea || e.data !== 3'b000 || e.cyc != t0 + k) bad++;
            if (int'(e.addr[6:0]) > maxy) maxy = int'(e.addr[6:0]);
        end
        checkOutput({tag, "_sequence"}, bad, 0);
        checkOutput({tag, "_max_y"}, maxy, YM);
        checkOutput({tag, "_play_time"}, time_left, RS);
        for (int x = 0; x <= XM; x++)
            for (int y = 0; y <= YM; y++)
                arena[{8'(x), 7'(y)}] = 3'b000;
    endtask

    // Wait for RESULT and compare counts/winner against the arena.
    task automatic checkTally(input string tag, input int tally_start);
        int exp_c[4];
        int best;
        for (int i = 0; i < NCELLS + 20 && !done; i++) @(negedge CLOCK_50);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_length"}, cyc - tally_start, NCELLS + 2);
        checkOutput({tag, "_busy"}, {running, busy}, 0);
        for (int i = 0; i < 4; i++) exp_c[i] = 0;
        for (int x = 0; x <= XM; x++)
            for (int y = 0; y <= YM; y++)
                case (arena[{8'(x), 7'(y)}])
                    3'b001:  exp_c[0]++;
                    3'b010:  exp_c[1]++;
                    3'b100:  exp_c[2]++;
                    3'b110:  exp_c[3]++;
                    default: ;
                endcase
        best = 0;
        for (int i = 1; i < 4; i++) if (exp_c[i] > exp_c[best]) best = i;
        checkOutput({tag, "_p1"}, p1_count, exp_c[0]);
        checkOutput({tag, "_p2"}, p2_count, exp_c[1]);
        checkOutput({tag, "_p3"}, p3_count, exp_c[2]);
        checkOutput({tag, "_p4"}, p4_count, exp_c[3]);
        checkOutput({tag, "_winner"}, winner, best);
    endtask

    task automatic backdoorWrite(input logic [7:0] x, input logic [6:0] y, input logic [2:0] d);
        bd_we   = 1'b1;
        bd_addr = {x, y};
        bd_data = d;
        @(negedge CLOCK_50);
        bd_we   = 1'b0;
        arena[{x, y}] = d;
    endtask

    initial begin
        int base, nlog, t0, tstart;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        resetn    = 1'b0;
        start     = 1'b0;
        move_tick = 1'b0;
        sec_tick  = 1'b0;
        bd_we     = 1'b0;
        bd_addr   = '0;
        bd_data   = '0;
        p1 = '0; p2 = '0; p3 = '0; p4 = '0;
        idle(3);
        resetn = 1'b1;
        idle(1);
        checkReset("por");

        // Reset in the middle of a clear sweep.
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(10);
        checkOutput("midclr_wren", ram_wren, 1);
        #2 resetn = 1'b0;
        #1 checkOutput("midclr_async_wren", ram_wren, 0);
        nlog = wlog.size();
        idle(3);
        checkOutput("midclr_no_writes", wlog.size() - nlog, 0);
        checkReset("midclr");
        resetn = 1'b1;
        idle(1);

        // Round 1.
        doClear("r1_clr");

        // Directed burst with out-of-range slots, plus a second tick mid-burst.
        p1 = {8'd5, 7'd3};
        p2 = {8'($urandom_range(0, XM)), 7'($urandom_range(0, YM))};
        p3 = {8'd200, 7'd3};
        p4 = {8'd3, 7'd9};
        base = wlog.size();
        applyStimulus(1'b0, 1'b1, 1'b0);
        t0 = cyc;
        expectBurst(t0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectBurst(t0 + 5);
        idle(12);
        compareWrites("paint_double", base);
        checkOutput("paint_double_run", running, 1);

        // start during PAINT must not restart the round.
        randomizePlayers();
        base = wlog.size();
        applyStimulus(1'b0, 1'b1, 1'b0);
        t0 = cyc;
        expectBurst(t0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(6);
        compareWrites("paint_start_ign", base);
        checkOutput("start_ign_time", time_left, RS);
        checkOutput("start_ign_run", running, 1);

        // Randomised bursts.
        for (int it = 0; it < 8; it++) begin
            randomizePlayers();
            base = wlog.size();
            applyStimulus(1'b0, 1'b1, 1'b0);
            t0 = cyc;
            expectBurst(t0);
            idle(4 + $urandom_range(0, 3));
            compareWrites("paint_rand", base);
        end

        // Timer: first second, then expiry coincident with a move.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("sec_dec", time_left, RS - 1);
        idle(1);
        randomizePlayers();
        base = wlog.size();
        applyStimulus(1'b0, 1'b1, 1'b1);
        t0 = cyc;
        expectBurst(t0);
        checkOutput("coinc_time0", time_left, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("sec_saturate", time_left, 0);
        idle(3);
        checkOutput("coinc_play_gap", running, 1);
        idle(1);
        checkOutput("coinc_tally", {running, busy}, 2'b01);
        compareWrites("coinc_paint", base);
        tstart = cyc;
        checkTally("r1_tally", tstart);

        // Round 2: restart from RESULT and tally a preloaded arena.
        doClear("r2_clr");
        backdoorWrite(8'd0, 7'd0, 3'b010);
        backdoorWrite(8'd1, 7'd1, 3'b010);
        backdoorWrite(8'd2, 7'd2, 3'b010);
        backdoorWrite(8'd3, 7'd3, 3'b100);
        backdoorWrite(8'd4, 7'd4, 3'b100);
        backdoorWrite(8'd5, 7'd5, 3'b100);
        backdoorWrite(8'd6, 7'd0, 3'b001);
        backdoorWrite(8'd7, 7'd5, 3'b111);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(1);
        checkOutput("r2_tally_start", {running, busy}, 2'b01);
        tstart = cyc;
        checkTally("r2_tally", tstart);
        checkOutput("preload_counts", {p1_count, p2_count, p3_count, p4_count},
                    {15'd1, 15'd3, 15'd3, 15'd0});
        checkOutput("preload_winner", winner, 2'b01);

        // start while reset is held is ignored.
        resetn = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rst_beats_start", {busy, done}, 0);
        resetn = 1'b1;
        idle(2);
        checkOutput("after_rst_idle", {busy, ram_wren}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
